systolic_row_feeder: RTL and testbench
======================================

Name: systolic_row_feeder

Overview:
- Streams an im2col matrix (M rows of N words, row-major) from the synchronous-read scratch memory into the X port of the systolic array, one full row vector per handshake.
- Generalised successor of the bench-level row counter:
  - base address, row stride, row count and row width are parametrised;
  - supports valid/ready backpressure through a small row FIFO;
  - appends a programmable number of zero rows so the array pipeline drains.
- Sits between the memory read port and systolic_array; started by im2col completion.

Parameters:
- M, 20, number of im2col rows to stream
- N, 9, words per row (array input lanes)
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, memory address width
- SRC_BASE, 32'h00002000, word address of row 0 word 0
- ROW_STRIDE, N, word-address distance between consecutive rows
- PAD_ROWS, 13, zero rows emitted after row M-1 (default N+K-1 with K=5)
- FIFO_DEPTH, 2, output row buffer depth (power of two, >=2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a stream
- mem_rd_en  out  1  read request this cycle
- addr_rd  out  ADDR_WIDTH  read word address
- data_rd  in  DATA_WIDTH  read data, valid one cycle after mem_rd_en
- x_row  out  DATA_WIDTH*N  row vector; lane j at bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
- x_valid  out  1  x_row valid
- x_ready  in  1  consumer accepts x_row
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse after final row (including pads) accepted

Behaviour:
- Reset (rst low, async): all state cleared. State=IDLE; mem_rd_en=0, addr_rd=0, x_row=0, x_valid=0, busy=0, done=0; FIFO empty; counters zero.
- FSM states and transitions:
  - IDLE --start--> FETCH.
  - FETCH --last word of row M-1 issued--> WAIT.
  - WAIT --last data captured--> PAD, or EMPTYQ if PAD_ROWS=0.
  - PAD --PAD_ROWS zero rows pushed--> EMPTYQ.
  - EMPTYQ --FIFO empty--> IDLE, pulsing done.
- busy is high in every state except IDLE.
- start while busy is ignored.
- Fetch addressing: word j of row r is read at SRC_BASE + r*ROW_STRIDE + j. Words are issued back-to-back, one per cycle, j = 0..N-1.
- Fetch credit: a row's first read issues only if (FIFO occupancy + rows in flight) < FIFO_DEPTH; at most one row is in flight. Once a row starts, its N reads are never interrupted.
- Assembly: data_rd captured the cycle after each read into lane j of an assembly register. The full row is pushed into the FIFO on the edge after lane N-1 is captured.
- Latency: start sampled at edge t.
  - mem_rd_en is high in cycles t+1..t+N.
  - x_valid rises at t+N+2.
  - With x_ready held high, the steady-state rate is one row every N cycles.
- Pad rows are all-zero vectors. Each is pushed one per cycle while the FIFO has space; no memory reads are issued for them.
- Output handshake: x_row/x_valid come from the FIFO head. A transfer occurs when x_valid && x_ready. While x_valid is high and x_ready is low, x_row must hold stable. x_row reads 0 when x_valid is low.
- Full FIFO: no pushes; the fetch is stalled by the credit rule. Data in flight always has a reserved slot.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- done: pulses for exactly one cycle on the cycle after the last pop. A new start is accepted in the same cycle done is high.
- Arithmetic: row and word counters are sized $clog2 of their limits plus 1. Address arithmetic wraps at ADDR_WIDTH bits without error.

Optional Feature:
- Macro FEEDER_PERF_EN.
- When defined: adds output port stall_cnt (32 bits). It counts cycles with x_valid && !x_ready, is cleared on accepted start, saturates at 32'hFFFFFFFF, and resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package feeder_pkg: FSM state enum (IDLE, FETCH, WAIT, PAD, EMPTYQ) and a lane-slice helper function.
- One sub-module is natural: row_fifo, a parametrised width/depth synchronous FIFO with full/empty and simultaneous push/pop.

Test Plan:
- Basic stream. Setup: M=4, N=3, PAD_ROWS=0, mem[SRC_BASE+i]=i+1, x_ready=1. Required response: x_row values {3,2,1},{6,5,4},{9,8,7},{12,11,10} (lane 0 = LSB); first x_valid at t+5; done one cycle after the 4th pop.
- Padding. Same setup with PAD_ROWS=2. Required response: 6 rows; the last two are all-zero; exactly 12 memory reads issued.
- Backpressure. Hold x_ready=0 for 20 cycles after the first x_valid. Required response: x_row stays {3,2,1}; mem_rd_en stops after 2 rows are buffered; no rows lost or duplicated after release.
- Reset mid-stream. Pull rst low during row 2 fetch. Required response: outputs drop to reset values immediately; a new start replays from row 0.
- Ignored start. Pulse start during FETCH. Required response: stream unaffected; exactly one done.
- FEEDER_PERF_EN. Backpressure case with the macro defined. Required response: stall_cnt=20 at done.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared types and helpers for the systolic row feeder.
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PAD,
        EMPTYQ
    } feeder_state_e;

    // Bit offset of lane 'lane' inside a packed row of 'width'-bit words.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/row_fifo.sv
// Generic synchronous FIFO, WIDTH bits by DEPTH entries (DEPTH a power of two, >= 2).
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module row_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/systolic_row_feeder.sv
// Streams M rows of N words from sync-read memory to the array X port, then PAD_ROWS zero rows; FEEDER_PERF_EN adds stall_cnt.
// Latency: start at edge t -> reads in cycles t+1..t+N, first x_valid at edge t+N+2; one row per N cycles in steady state.
// Backpressure: x_valid/x_ready from a row FIFO; a row fetch only starts when a FIFO slot is reserved for it.
module systolic_row_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned           M          = 20,
    parameter int unsigned           N          = 9,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = ADDR_WIDTH'(32'h0000_2000),
    parameter int unsigned           ROW_STRIDE = N,
    parameter int unsigned           PAD_ROWS   = 13,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   addr_rd,
    input  logic [DATA_WIDTH-1:0]   data_rd,
    output logic [DATA_WIDTH*N-1:0] x_row,
    output logic                    x_valid,
    input  logic                    x_ready,
`ifdef FEEDER_PERF_EN
    output logic [31:0]             stall_cnt,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int RW       = $clog2(M) + 1;
    localparam int WW       = $clog2(N) + 1;
    localparam int LIW      = (N > 1) ? $clog2(N) : 1;
    localparam int PW       = $clog2(PAD_ROWS + 1) + 1;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int ROW_BITS = DATA_WIDTH * N;

    feeder_state_e state_q, state_d;

    logic [RW-1:0]         row_cnt_q;
    logic [WW-1:0]         word_cnt_q;
    logic [PW-1:0]         pad_cnt_q;
    logic [CW-1:0]         inflight_q;
    logic                  rd_vld_q;
    logic [LIW-1:0]        rd_lane_q;
    logic                  row_full_q;
    logic [DATA_WIDTH-1:0] lane_q [N];
    logic [ROW_BITS-1:0]   asm_row;

    logic                  fifo_push_vld;
    logic [ROW_BITS-1:0]   fifo_push_dat;
    logic [ROW_BITS-1:0]   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;

    logic                  credit_ok;
    logic                  row_first;
    logic                  row_last_word;
    logic                  last_row;
    logic                  row_start;
    logic                  start_ok;
    logic                  pad_push;

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign asm_row[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = lane_q[j];
    end

    // Rows already buffered plus rows being fetched must never exceed the FIFO.
    assign credit_ok     = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH);
    assign row_first     = (word_cnt_q == '0);
    assign row_last_word = (word_cnt_q == WW'(N - 1));
    assign last_row      = (row_cnt_q == RW'(M - 1));
    assign row_start     = mem_rd_en && row_first;
    assign start_ok      = start && ((state_q == IDLE) || ((state_q == EMPTYQ) && fifo_empty));
    assign busy          = (state_q != IDLE);

    assign addr_rd = mem_rd_en ? (SRC_BASE + ADDR_WIDTH'(row_cnt_q) * ADDR_WIDTH'(ROW_STRIDE)
                                  + ADDR_WIDTH'(word_cnt_q))
                               : '0;

    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        pad_push  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                mem_rd_en = !row_first || credit_ok;
                if (mem_rd_en && row_last_word && last_row) state_d = WAIT;
            end
            WAIT: begin
                if (row_full_q && (inflight_q == CW'(1))) begin
                    state_d = (PAD_ROWS == 0) ? EMPTYQ : PAD;
                end
            end
            PAD: begin
                pad_push = !fifo_full;
                if (pad_push && (pad_cnt_q == PW'(PAD_ROWS - 1))) state_d = EMPTYQ;
            end
            EMPTYQ: begin
                if (fifo_empty) begin
                    done    = 1'b1;
                    state_d = start ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            word_cnt_q <= '0;
            pad_cnt_q  <= '0;
            inflight_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_lane_q  <= '0;
            row_full_q <= 1'b0;
            for (int j = 0; j < N; j++) begin
                lane_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_vld_q   <= mem_rd_en;
            rd_lane_q  <= word_cnt_q[LIW-1:0];
            row_full_q <= rd_vld_q && (rd_lane_q == LIW'(N - 1));
            if (rd_vld_q) begin
                lane_q[rd_lane_q] <= data_rd;
            end
            if (start_ok) begin
                row_cnt_q  <= '0;
                word_cnt_q <= '0;
                pad_cnt_q  <= '0;
            end else begin
                if (mem_rd_en) begin
                    if (row_last_word) begin
                        word_cnt_q <= '0;
                        row_cnt_q  <= row_cnt_q + RW'(1);
                    end else begin
                        word_cnt_q <= word_cnt_q + WW'(1);
                    end
                end
                if (pad_push) begin
                    pad_cnt_q <= pad_cnt_q + PW'(1);
                end
            end
            case ({row_start, row_full_q})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: ;
            endcase
        end
    end

    // The assembled row is pushed the cycle after its last lane lands; pads never coincide with it.
    assign fifo_push_vld = row_full_q || pad_push;
    assign fifo_push_dat = pad_push ? '0 : asm_row;

    row_fifo #(
        .WIDTH (ROW_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (fifo_push_vld),
        .push_dat (fifo_push_dat),
        .pop_rdy  (x_ready),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign x_valid = !fifo_empty;
    assign x_row   = fifo_empty ? '0 : fifo_head;

`ifdef FEEDER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (x_valid && !x_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Scoreboard bench for systolic_row_feeder: one instance without padding, one with two pad rows.
module tb_systolic_row_feeder;

    localparam int M    = 4;
    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int FD   = 2;
    localparam int ROWW = DW * N;
    localparam logic [AW-1:0] BASE = 32'h0000_2000;

    typedef logic [ROWW-1:0] row_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          start   = 1'b0;
    logic          x_ready = 1'b1;
    logic          mem_rd_en [2];
    logic [AW-1:0] addr_rd   [2];
    logic [DW-1:0] data_rd   [2];
    row_t          x_row     [2];
    logic          x_valid   [2];
    logic          busy      [2];
    logic          done      [2];
`ifdef FEEDER_PERF_EN
    logic [31:0]   stall_cnt [2];
`endif

    int   checks   = 0;
    int   failures = 0;
    int   rd_cnt   [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    bit   pop_prev [2];
    bit   hold_prev[2];
    row_t row_prev [2];
    row_t exp_q0[$];
    row_t exp_q1[$];

    always #5 clk = ~clk;

    systolic_row_feeder #(
        .M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_BASE(BASE),
        .ROW_STRIDE(N), .PAD_ROWS(0), .FIFO_DEPTH(FD)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en[0]), .addr_rd(addr_rd[0]), .data_rd(data_rd[0]),
        .x_row(x_row[0]), .x_valid(x_valid[0]), .x_ready(x_ready),
`ifdef FEEDER_PERF_EN
        .stall_cnt(stall_cnt[0]),
`endif
        .busy(busy[0]), .done(done[0])
    );

    systolic_row_feeder #(
        .M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_BASE(BASE),
        .ROW_STRIDE(N), .PAD_ROWS(2), .FIFO_DEPTH(FD)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en[1]), .addr_rd(addr_rd[1]), .data_rd(data_rd[1]),
        .x_row(x_row[1]), .x_valid(x_valid[1]), .x_ready(x_ready),
`ifdef FEEDER_PERF_EN
        .stall_cnt(stall_cnt[1]),
`endif
        .busy(busy[1]), .done(done[1])
    );

    // Synchronous-read memory: mem[BASE+i] = i+1.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_rd_en[i]) begin
                data_rd[i] <= addr_rd[i] - BASE + 32'd1;
                rd_cnt[i]  <= rd_cnt[i] + 1;
            end
        end
    end

    function automatic void check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic row_t mk_row(input int r);
        row_t v = '0;
        for (int j = N - 1; j >= 0; j--) begin
            v = (v << DW) | row_t'(r * N + j + 1);
        end
        return v;
    endfunction

    function automatic int q_size(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic row_t q_pop(input int i);
        if (i == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic expect_stream();
        for (int r = 0; r < M; r++) begin
            exp_q0.push_back(mk_row(r));
            exp_q1.push_back(mk_row(r));
        end
        for (int p = 0; p < 2; p++) exp_q1.push_back('0);
    endtask

    // Monitor: samples 1 ns after the falling edge, after the stimulus has updated inputs.
    always begin
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                hold_prev[i] = 1'b0;
                pop_prev[i]  = 1'b0;
            end else begin
                if (hold_prev[i])
                    check($sformatf("hold_stable_dut%0d", i), {x_valid[i], x_row[i]}, {1'b1, row_prev[i]});
                if (!x_valid[i])
                    check($sformatf("zero_when_invalid_dut%0d", i), x_row[i], '0);
                if (x_valid[i] && x_ready) begin
                    if (q_size(i) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_row_dut%0d: got %0h expected no row", i, x_row[i]);
                    end else begin
                        check($sformatf("row_data_dut%0d", i), x_row[i], q_pop(i));
                    end
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    check($sformatf("done_after_last_pop_dut%0d", i), {pop_prev[i], q_size(i) == 0}, 2'b11);
                end
                pop_prev[i]  = x_valid[i] && x_ready;
                hold_prev[i] = x_valid[i] && !x_ready;
                row_prev[i]  = x_row[i];
            end
        end
    end

    task automatic stream(input int hold, input bit ign);
        int r0, r1, d0, d1, lat, cnt;
        r0 = rd_cnt[0];
        r1 = rd_cnt[1];
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        expect_stream();
        if (hold > 0) x_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {busy[0], busy[1], mem_rd_en[0]}, 3'b111);
        lat = 0;
        if (ign) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat = 2;
        end
        while (!x_valid[0] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("first_valid_latency", lat, N + 2);
        check("first_valid_both", {x_valid[0], x_valid[1]}, 2'b11);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("bp_reads_two_rows", rd_cnt[0] - r0, 2 * N);
            check("bp_rd_en_stopped", mem_rd_en[0], 1'b0);
            check("bp_head_row", x_row[0], mk_row(0));
            x_ready = 1'b1;
        end
        cnt = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("done_within_budget", cnt < 300, 1'b1);
        repeat (4) @(negedge clk);
        check("reads_dut0", rd_cnt[0] - r0, M * N);
        check("reads_dut1", rd_cnt[1] - r1, M * N);
        check("one_done_dut0", done_cnt[0] - d0, 1);
        check("one_done_dut1", done_cnt[1] - d1, 1);
        check("rows_all_delivered", {q_size(0) == 0, q_size(1) == 0}, 2'b11);
        check("idle_after_done", {busy[0], busy[1]}, 2'b00);
`ifdef FEEDER_PERF_EN
        check("stall_cnt_dut0", stall_cnt[0], hold);
        check("stall_cnt_dut1", stall_cnt[1], hold);
`endif
    endtask

    initial begin
        int cnt;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs_dut%0d", i),
                  {mem_rd_en[i], addr_rd[i], x_row[i], x_valid[i], busy[i], done[i]}, '0);
        rst = 1'b1;
        @(negedge clk);

        stream(0, 1'b0);
        stream(0, 1'b1);
        stream(20, 1'b0);

        expect_stream();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(mem_rd_en[0] && addr_rd[0] == BASE + AW'(2 * N)) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("row2_fetch_reached", cnt < 50, 1'b1);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("async_reset_outputs_dut%0d", i),
                  {mem_rd_en[i], addr_rd[i], x_row[i], x_valid[i], busy[i], done[i]}, '0);
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        stream(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
